// File: rtl/sa_isa_pkg.sv
// Package sa_isa_pkg
// Purpose : SA instruction-set definitions shared by the sequencer and its decoder.
//           Instruction word layout: [31:28] opcode, [27:16] SRAM address, [15:0] length.
// Contents: opcode_e, field positions/widths, sa_cmd_t command payload, seq_state_e.
package sa_isa_pkg;

    localparam int unsigned INST_W   = 32;
    localparam int unsigned OPC_W    = 4;
    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned LEN_W    = 16;
    localparam int unsigned OPC_MSB  = 31;
    localparam int unsigned OPC_LSB  = 28;
    localparam int unsigned ADDR_MSB = 27;
    localparam int unsigned ADDR_LSB = 16;
    localparam int unsigned CNT_W    = 4;   // outstanding-command counter width

    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 4'h0,
        OP_LD_W = 4'h1,
        OP_LD_A = 4'h2,
        OP_MAC  = 4'h3,
        OP_ST   = 4'h4,
        OP_SYNC = 4'h5,
        OP_HALT = 4'hF
    } opcode_e;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } sa_cmd_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_WAIT_RD   = 3'd2,
        S_DECODE    = 3'd3,
        S_ISSUE     = 3'd4,
        S_SYNC_WAIT = 3'd5,
        S_DONE      = 3'd6
    } seq_state_e;

endpackage

// File: rtl/sa_inst_decoder.sv
// Module sa_inst_decoder
// Purpose : Combinational decode of one SA instruction word into a command payload
//           plus class flags. Exactly one flag is high for any input word.
// Ports   : inst        in  32  instruction word
//           cmd_c       out     opcode/addr/len fields
//           is_issue_c  out 1   LD_W, LD_A, MAC or ST
//           is_sync_c   out 1   SYNC
//           is_halt_c   out 1   HALT
//           is_nop_c    out 1   NOP
//           illegal_c   out 1   opcodes 6..E
module sa_inst_decoder
    import sa_isa_pkg::*;
(
    input  logic [INST_W-1:0] inst,
    output sa_cmd_t           cmd_c,
    output logic              is_issue_c,
    output logic              is_sync_c,
    output logic              is_halt_c,
    output logic              is_nop_c,
    output logic              illegal_c
);

    // Field extraction and opcode classification
    always_comb begin
        cmd_c.opcode = inst[OPC_MSB:OPC_LSB];
        cmd_c.addr   = inst[ADDR_MSB:ADDR_LSB];
        cmd_c.len    = inst[LEN_W-1:0];
        is_issue_c   = 1'b0;
        is_sync_c    = 1'b0;
        is_halt_c    = 1'b0;
        is_nop_c     = 1'b0;
        illegal_c    = 1'b0;
        case (inst[OPC_MSB:OPC_LSB])
            OP_NOP:                          is_nop_c   = 1'b1;
            OP_LD_W, OP_LD_A, OP_MAC, OP_ST: is_issue_c = 1'b1;
            OP_SYNC:                         is_sync_c  = 1'b1;
            OP_HALT:                         is_halt_c  = 1'b1;
            default:                         illegal_c  = 1'b1;
        endcase
    end

endmodule

// File: rtl/sa_instruction_sequencer.sv
// Module sa_instruction_sequencer
// Purpose : Fetches instruction words from the SA instruction buffer starting at
//           start_pc, decodes them and issues SA commands over a valid/ready channel.
//           Honours SYNC (drain outstanding commands) and HALT; reports busy/done/err.
// Ports   : clk, reset (sync, active-high)
//           start, start_pc             run request (accepted in IDLE only)
//           ib_rd_en, ib_rd_addr        buffer read request
//           ib_rd_data                  buffer read data, one cycle after ib_rd_en
//           cmd_valid, cmd_ready        command handshake
//           cmd_opcode/cmd_addr/cmd_len command payload
//           sa_done                     one pulse per completed command
//           busy, done, err, cur_pc     status
//           perf_cycles, perf_stall     only with SA_SEQ_PERF_CNT_EN defined
// Macro   : SA_SEQ_PERF_CNT_EN adds busy-cycle and stall-cycle counters.
module sa_instruction_sequencer
    import sa_isa_pkg::*;
#(
    parameter int unsigned IB_DEPTH = 16,
    parameter int unsigned PC_W     = $clog2(IB_DEPTH),
    parameter int unsigned DATA_W   = 32
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PC_W-1:0]   start_pc,
    output logic              ib_rd_en,
    output logic [PC_W-1:0]   ib_rd_addr,
    input  logic [DATA_W-1:0] ib_rd_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [3:0]        cmd_opcode,
    output logic [11:0]       cmd_addr,
    output logic [15:0]       cmd_len,
    input  logic              sa_done,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [PC_W-1:0]   cur_pc
`ifdef SA_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stall
`endif
);

    localparam logic [PC_W-1:0] PC_LAST = PC_W'(IB_DEPTH - 1);

    seq_state_e        state_q, state_n;
    logic [PC_W-1:0]   pc_q, pc_n;
    logic [DATA_W-1:0] ir_q;
    sa_cmd_t           dec_cmd_c, cmd_q;
    logic              is_issue_c, is_sync_c, is_halt_c, is_nop_c, illegal_c;
    logic [CNT_W-1:0]  outst_q, outst_n;
    logic              cnt_err_c, err_set_c, start_acc_c, pc_adv_c, hs_c, err_n_c;
    logic              ib_rd_en_q, cmd_valid_q, busy_q, done_q, err_q;

    sa_inst_decoder u_dec (
        .inst       (ir_q),
        .cmd_c      (dec_cmd_c),
        .is_issue_c (is_issue_c),
        .is_sync_c  (is_sync_c),
        .is_halt_c  (is_halt_c),
        .is_nop_c   (is_nop_c),
        .illegal_c  (illegal_c)
    );

    assign hs_c = cmd_valid_q && cmd_ready;

    // Outstanding-command counter: issue and completion in the same cycle cancel
    always_comb begin
        outst_n   = outst_q;
        cnt_err_c = 1'b0;
        if (hs_c && !sa_done) begin
            if (outst_q == '1) cnt_err_c = 1'b1;
            else               outst_n   = outst_q + CNT_W'(1);
        end else if (sa_done && !hs_c) begin
            if (outst_q == '0) cnt_err_c = 1'b1;
            else               outst_n   = outst_q - CNT_W'(1);
        end
    end

    // Next-state logic; every pc advance funnels through pc_adv_c so wrap is caught once
    always_comb begin
        state_n     = state_q;
        pc_n        = pc_q;
        err_set_c   = 1'b0;
        start_acc_c = 1'b0;
        pc_adv_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_acc_c = 1'b1;
                    pc_n        = start_pc;
                    state_n     = S_FETCH;
                end
            end
            S_FETCH:   state_n = S_WAIT_RD;
            S_WAIT_RD: state_n = S_DECODE;
            S_DECODE: begin
                if (illegal_c) begin
                    err_set_c = 1'b1;
                    state_n   = S_DONE;
                end else if (is_halt_c) begin
                    state_n = S_DONE;
                end else if (is_sync_c) begin
                    state_n = S_SYNC_WAIT;
                end else if (is_issue_c) begin
                    state_n = S_ISSUE;
                end else if (is_nop_c) begin
                    pc_adv_c = 1'b1;
                end
            end
            S_ISSUE:     if (hs_c) pc_adv_c = 1'b1;
            S_SYNC_WAIT: if (outst_q == '0) pc_adv_c = 1'b1;
            S_DONE:      state_n = S_IDLE;
            default:     state_n = S_IDLE;
        endcase
        if (pc_adv_c) begin
            if (pc_q == PC_LAST) begin
                err_set_c = 1'b1;
                state_n   = S_DONE;
            end else begin
                pc_n    = pc_q + PC_W'(1);
                state_n = S_FETCH;
            end
        end
    end

    // Sticky error: an accepted start clears it, but a same-cycle counter fault still lands
    assign err_n_c = (err_q && !start_acc_c) || err_set_c || cnt_err_c;

    // State, datapath and registered outputs (outputs follow the next state)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            cmd_q       <= '0;
            outst_q     <= '0;
            ib_rd_en_q  <= 1'b0;
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_n;
            pc_q        <= pc_n;
            outst_q     <= outst_n;
            if (state_q == S_WAIT_RD) ir_q <= ib_rd_data;
            if (state_q == S_DECODE && state_n == S_ISSUE) cmd_q <= dec_cmd_c;
            ib_rd_en_q  <= (state_n == S_FETCH);
            cmd_valid_q <= (state_n == S_ISSUE);
            busy_q      <= (state_n != S_IDLE);
            done_q      <= (state_n == S_DONE);
            err_q       <= err_n_c;
        end
    end

    assign ib_rd_en   = ib_rd_en_q;
    assign ib_rd_addr = pc_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_opcode = cmd_q.opcode;
    assign cmd_addr   = cmd_q.addr;
    assign cmd_len    = cmd_q.len;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign cur_pc     = pc_q;

`ifdef SA_SEQ_PERF_CNT_EN
    logic [31:0] perf_cycles_q, perf_stall_q;
    logic        stall_c;

    assign stall_c = (cmd_valid_q && !cmd_ready) || (state_q == S_SYNC_WAIT);

    // Saturating busy/stall counters; cleared by an accepted start, frozen while idle
    always_ff @(posedge clk) begin
        if (reset || start_acc_c) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (busy_q && perf_cycles_q != '1) perf_cycles_q <= perf_cycles_q + 32'd1;
            if (stall_c && perf_stall_q != '1) perf_stall_q  <= perf_stall_q + 32'd1;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule
